// File: rtl/paddle_sprite_if.sv
// Controller-side bundle of the player paddle: update strobe, controls, pixel
// coordinates in; registered colour and paddle status out.
interface paddle_sprite_if;
   logic       step_en;
   logic       control_up;
   logic       control_down;
   logic [9:0] row;
   logic [9:0] col;
   logic [2:0] rgb;
   logic [9:0] pos_y;
   logic       moving;

   modport master (
      output step_en, control_up, control_down, row, col,
      input  rgb, pos_y, moving
   );

   modport slave (
      input  step_en, control_up, control_down, row, col,
      output rgb, pos_y, moving
   );
endinterface

// File: rtl/paddle_sprite.sv
// Player paddle for the Pong VGA pipeline: clamped vertical motion with
// held-direction step acceleration and a registered pixel colour.
module paddle_sprite #(
   parameter int unsigned START_POSX = 100,
   parameter int unsigned START_POSY = 100,
   parameter logic [2:0]  COLOR      = 3'b111,
   parameter int unsigned HEIGHT     = 70,
   parameter int unsigned WIDTH      = 10,
   parameter int unsigned Y_MIN      = 0,
   parameter int unsigned Y_MAX      = 480,
   parameter int unsigned SPEED      = 10,
   parameter int unsigned STEP_INIT  = 1,
   parameter int unsigned STEP_MAX   = 4,
   parameter int unsigned ACCEL_HOLD = 8
) (
   input logic             tick,
   input logic             reset,
   paddle_sprite_if.slave  bus
);

   if (SPEED == 0 || SPEED > 255 || Y_MAX > 1024 || Y_MAX < Y_MIN + HEIGHT ||
       START_POSY < Y_MIN || START_POSY + HEIGHT > Y_MAX || STEP_INIT > STEP_MAX ||
       STEP_MAX > 63 || ACCEL_HOLD == 0 || ACCEL_HOLD > 256) begin : g_bad_params
      $error("paddle_sprite: illegal parameter set");
   end

   localparam logic [9:0]  PosInit   = 10'(START_POSY);
   localparam logic [10:0] YMin      = 11'(Y_MIN);
   localparam logic [10:0] YMax      = 11'(Y_MAX);
   localparam logic [10:0] YLow      = 11'(Y_MAX - HEIGHT);
   localparam logic [10:0] Height    = 11'(HEIGHT);
   localparam logic [10:0] XLo       = 11'(START_POSX);
   localparam logic [10:0] XHi       = 11'(START_POSX + WIDTH);
   localparam logic [7:0]  TimerLast = 8'(SPEED - 1);
   localparam logic [5:0]  StepInit  = 6'(STEP_INIT);
   localparam logic [5:0]  StepMax   = 6'(STEP_MAX);
   localparam logic [7:0]  HoldLast  = 8'(ACCEL_HOLD - 1);

   typedef enum logic [1:0] {DirNone, DirUp, DirDown} dir_e;

   dir_e        dir_q, dir_d, dir_in;
   logic [7:0]  timer_q, timer_d;
   logic [9:0]  pos_q, pos_d;
   logic [5:0]  step_q, step_d, step_base;
   logic [7:0]  hold_q, hold_d, hold_base;
   logic [2:0]  rgb_q, rgb_d;
   logic        moving_q, moving_d;
   logic        move_event;
   logic [10:0] pos_ext, step_ext, up_pos, dn_pos, new_pos;

   always_comb begin
      timer_d  = timer_q;
      pos_d    = pos_q;
      step_d   = step_q;
      hold_d   = hold_q;
      dir_d    = dir_q;
      moving_d = moving_q;

      move_event = bus.step_en && (timer_q == TimerLast);
      if (bus.step_en) begin
         timer_d = move_event ? 8'd0 : timer_q + 8'd1;
      end

      if (bus.control_up && !bus.control_down) begin
         dir_in = DirUp;
      end else if (bus.control_down && !bus.control_up) begin
         dir_in = DirDown;
      end else begin
         dir_in = DirNone;
      end

      // A direction break restarts acceleration before this event is counted.
      step_base = (dir_in == dir_q) ? step_q : StepInit;
      hold_base = (dir_in == dir_q) ? hold_q : 8'd0;

      pos_ext  = {1'b0, pos_q};
      step_ext = {5'd0, step_base};
      up_pos   = (pos_ext < YMin + step_ext) ? YMin : pos_ext - step_ext;
      dn_pos   = (pos_ext + step_ext + Height > YMax) ? YLow : pos_ext + step_ext;
      new_pos  = (dir_in == DirUp) ? up_pos : dn_pos;

      if (move_event) begin
         dir_d = dir_in;
         case (dir_in)
            DirUp, DirDown: begin
               pos_d    = new_pos[9:0];
               moving_d = (new_pos != pos_ext);
               if (hold_base == HoldLast) begin
                  hold_d = 8'd0;
                  step_d = (step_base >= StepMax) ? StepMax : step_base + 6'd1;
               end else begin
                  hold_d = hold_base + 8'd1;
                  step_d = step_base;
               end
            end
            default: begin
               step_d   = StepInit;
               hold_d   = 8'd0;
               moving_d = 1'b0;
            end
         endcase
      end

      // Draw against the pre-update position.
      if ({1'b0, bus.col} >= XLo && {1'b0, bus.col} < XHi &&
          {1'b0, bus.row} >= pos_ext && {1'b0, bus.row} < pos_ext + Height) begin
         rgb_d = COLOR;
      end else begin
         rgb_d = 3'b000;
      end
   end

   always_ff @(posedge tick or posedge reset) begin
      if (reset) begin
         timer_q  <= 8'd0;
         pos_q    <= PosInit;
         step_q   <= StepInit;
         hold_q   <= 8'd0;
         dir_q    <= DirNone;
         rgb_q    <= 3'b000;
         moving_q <= 1'b0;
      end else begin
         timer_q  <= timer_d;
         pos_q    <= pos_d;
         step_q   <= step_d;
         hold_q   <= hold_d;
         dir_q    <= dir_d;
         rgb_q    <= rgb_d;
         moving_q <= moving_d;
      end
   end

   assign bus.rgb    = rgb_q;
   assign bus.pos_y  = pos_q;
   assign bus.moving = moving_q;

endmodule

// File: tb/tb_paddle_sprite.sv
// Self-checking bench for paddle_sprite: directed scenarios plus randomized
// traffic against an arithmetic reference model of the paddle.
module tb_paddle_sprite;

   localparam int SPEED      = 2;
   localparam int ACCEL_HOLD = 3;
   localparam int STEP_INIT  = 1;
   localparam int STEP_MAX   = 4;
   localparam int HEIGHT     = 70;
   localparam int WIDTH      = 10;
   localparam int Y_MIN      = 0;
   localparam int Y_MAX      = 480;
   localparam int START_POSX = 100;
   localparam int START_POSY = 100;
   localparam int COLOR      = 7;

   logic tick;
   logic reset;
   paddle_sprite_if bus ();

   paddle_sprite #(
      .START_POSX (START_POSX),
      .START_POSY (START_POSY),
      .COLOR      (3'b111),
      .HEIGHT     (HEIGHT),
      .WIDTH      (WIDTH),
      .Y_MIN      (Y_MIN),
      .Y_MAX      (Y_MAX),
      .SPEED      (SPEED),
      .STEP_INIT  (STEP_INIT),
      .STEP_MAX   (STEP_MAX),
      .ACCEL_HOLD (ACCEL_HOLD)
   ) dut (
      .tick  (tick),
      .reset (reset),
      .bus   (bus)
   );

   initial tick = 1'b0;
   always #5 tick = ~tick;

   int checks   = 0;
   int failures = 0;

   // Reference model state: position, step size, hold count, last direction
   // (0 none, 1 up, 2 down), strobe count, outputs.
   int m_pos, m_step, m_hold, m_last, m_timer, m_moving, m_rgb;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos    = START_POSY;
      m_timer  = 0;
      m_step   = STEP_INIT;
      m_hold   = 0;
      m_last   = 0;
      m_rgb    = 0;
      m_moving = 0;
   endtask

   task automatic model_edge();
      int dir, used, np, r, c;
      if (reset) begin
         model_reset();
         return;
      end
      r = int'(bus.row);
      c = int'(bus.col);
      m_rgb = (c >= START_POSX && c < START_POSX + WIDTH && r >= m_pos && r < m_pos + HEIGHT)
              ? COLOR : 0;
      if (!bus.step_en) return;
      m_timer++;
      if (m_timer < SPEED) return;
      m_timer = 0;
      dir = (bus.control_up && !bus.control_down) ? 1 :
            (bus.control_down && !bus.control_up) ? 2 : 0;
      if (dir == 0) begin
         m_step   = STEP_INIT;
         m_hold   = 0;
         m_moving = 0;
         m_last   = 0;
         return;
      end
      if (dir != m_last) begin
         m_step = STEP_INIT;
         m_hold = 0;
      end
      used = m_step;
      m_hold++;
      if (m_hold == ACCEL_HOLD) begin
         m_hold = 0;
         if (m_step < STEP_MAX) m_step++;
      end
      np = (dir == 1) ? m_pos - used : m_pos + used;
      if (np < Y_MIN) np = Y_MIN;
      if (np > Y_MAX - HEIGHT) np = Y_MAX - HEIGHT;
      m_moving = (np != m_pos) ? 1 : 0;
      m_pos    = np;
      m_last   = dir;
   endtask

   task automatic cycle();
      @(posedge tick);
      model_edge();
      #1;
      check_eq("pos_y", bus.pos_y, m_pos);
      check_eq("moving", bus.moving, m_moving);
      check_eq("rgb", bus.rgb, m_rgb);
   endtask

   task automatic set_ctl(input logic up, input logic down);
      bus.control_up   = up;
      bus.control_down = down;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int exp_down [7] = '{101, 102, 103, 105, 107, 109, 112};
   int draw_row [4] = '{100, 100, 169, 170};
   int draw_col [4] = '{100, 110, 109, 105};
   int draw_rgb [4] = '{7, 0, 7, 0};

   initial begin
      reset       = 1'b1;
      bus.step_en = 1'b1;
      bus.row     = 10'd0;
      bus.col     = 10'd0;
      set_ctl(1'b0, 1'b0);
      model_reset();
      #1;
      check_eq("reset_pos", bus.pos_y, START_POSY);
      check_eq("reset_rgb", bus.rgb, 0);
      check_eq("reset_moving", bus.moving, 0);

      // Idle after reset.
      pulse_reset();
      for (int i = 0; i < 10; i++) begin
         cycle();
         check_eq("idle_pos", bus.pos_y, 100);
         check_eq("idle_moving", bus.moving, 0);
      end

      // Held down: accelerating sequence.
      pulse_reset();
      set_ctl(1'b0, 1'b1);
      for (int i = 0; i < 14; i++) begin
         cycle();
         if (i % 2 == 1) begin
            check_eq("down_seq", bus.pos_y, exp_down[i/2]);
            check_eq("down_moving", bus.moving, 1);
         end
      end

      // Clamp at the top, then at the bottom.
      set_ctl(1'b1, 1'b0);
      for (int i = 0; i < 200; i++) cycle();
      check_eq("clamp_top", bus.pos_y, 0);
      check_eq("clamp_top_moving", bus.moving, 0);
      set_ctl(1'b0, 1'b1);
      for (int i = 0; i < 400; i++) cycle();
      check_eq("clamp_bottom", bus.pos_y, 410);
      check_eq("clamp_bottom_moving", bus.moving, 0);

      // Both pressed breaks acceleration.
      pulse_reset();
      set_ctl(1'b0, 1'b1);
      for (int i = 0; i < 12; i++) cycle();
      set_ctl(1'b1, 1'b1);
      cycle();
      cycle();
      check_eq("both_pos", bus.pos_y, 109);
      check_eq("both_moving", bus.moving, 0);
      set_ctl(1'b0, 1'b1);
      cycle();
      cycle();
      check_eq("restart_step", bus.pos_y, 110);

      // Draw window.
      pulse_reset();
      set_ctl(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bus.row = 10'(draw_row[i]);
         bus.col = 10'(draw_col[i]);
         cycle();
         check_eq("draw_rgb", bus.rgb, draw_rgb[i]);
      end

      // Asynchronous reset mid-motion.
      pulse_reset();
      set_ctl(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) cycle();
      check_eq("pre_async_pos", bus.pos_y, 105);
      bus.row = 10'd110;
      bus.col = 10'd100;
      cycle();
      check_eq("pre_async_rgb", bus.rgb, 7);
      #3;
      reset = 1'b1;
      #1;
      check_eq("async_pos", bus.pos_y, 100);
      check_eq("async_rgb", bus.rgb, 0);
      check_eq("async_moving", bus.moving, 0);
      model_reset();
      #1;
      reset = 1'b0;
      cycle();
      check_eq("post_async_hold", bus.pos_y, 100);
      cycle();
      check_eq("post_async_step", bus.pos_y, 101);

      // Randomized traffic: direction chosen per block, with perturbations.
      for (int b = 0; b < 150; b++) begin
         int mode;
         mode = $urandom_range(0, 3);
         for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 7) == 0) mode = $urandom_range(0, 3);
            set_ctl(mode == 1 || mode == 3, mode == 2 || mode == 3);
            bus.step_en = ($urandom_range(0, 3) != 0);
            bus.row     = 10'($urandom_range(0, 500));
            bus.col     = 10'($urandom_range(90, 120));
            reset       = ($urandom_range(0, 299) == 0);
            cycle();
            reset = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/paddle_sprite.md
# paddle_sprite

Parametrised player paddle for the Pong VGA pipeline. It is the successor of the fixed-step rectangle paddle and adds configurable vertical bounds with clamping, a step-size acceleration mode for a held direction, a registered pixel output and status outputs. It sits between the controller inputs and the VGA colour mux, and is clocked by the game clock.

## Interface

Parameters:
- START_POSX, 100: fixed left column of the paddle.
- START_POSY, 100: top row after reset.
- COLOR, 3'b111: RGB value drawn inside the paddle.
- HEIGHT, 70: paddle height in rows.
- WIDTH, 10: paddle width in columns.
- Y_MIN, 0: smallest legal top row.
- Y_MAX, 480: exclusive bottom limit. pos_y + HEIGHT never exceeds Y_MAX.
- SPEED, 10: step_en pulses per move event. Legal range 1..255.
- STEP_INIT, 1: step size in rows after reset or after a direction break.
- STEP_MAX, 4: step-size ceiling. STEP_INIT ≤ STEP_MAX ≤ 63.
- ACCEL_HOLD, 8: consecutive same-direction move events before the step size grows by 1. ACCEL_HOLD = 1 grows the step on every event.

Ports:
- tick, in, 1: game clock. Every register updates on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- step_en, in, 1: single-cycle update strobe, for example once per frame.
- control_up, in, 1: move-up request.
- control_down, in, 1: move-down request.
- row, in, 10: current pixel row, synchronous to tick.
- col, in, 10: current pixel column, synchronous to tick.
- rgb, out, 3: registered pixel colour.
- pos_y, out, 10: current top row of the paddle.
- moving, out, 1: high if the last move event changed pos_y.

## Operation

- Reset state, applied asynchronously while reset is high: pos_y = START_POSY, timer = 0, step = STEP_INIT, hold = 0, last direction = none, rgb = 3'b000, moving = 0.
- Timer, 8 bits:
  - It advances only on edges where step_en = 1.
  - When timer == SPEED-1 and step_en = 1, a move event occurs and timer returns to 0.
  - With step_en = 0, timer holds its value.
- Direction is sampled at the move event:
  - up only gives UP.
  - down only gives DOWN.
  - both or neither gives NONE. Unlike the previous paddle, up has no priority over down.
- Move event with NONE: pos_y is held, step = STEP_INIT, hold = 0, moving = 0.
- Move event with UP or DOWN, same direction as the previous event:
  - If hold == ACCEL_HOLD-1: hold = 0 and step = min(step+1, STEP_MAX).
  - Otherwise hold = hold + 1.
- Move event with UP or DOWN, new direction: step = STEP_INIT and hold = 0 before the move is applied.
- The move always uses the step value held before any increment on this edge.
- Clamping, all arithmetic 11 bits wide with no wrap:
  - UP: pos_y = (pos_y < Y_MIN + step) ? Y_MIN : pos_y - step.
  - DOWN: pos_y = (pos_y + step + HEIGHT > Y_MAX) ? Y_MAX - HEIGHT : pos_y + step.
- moving = 1 exactly when the new pos_y differs from the old pos_y. A clamped no-change move gives moving = 0.
- Draw: rgb is registered to COLOR when START_POSX ≤ col < START_POSX+WIDTH and pos_y ≤ row < pos_y+HEIGHT, otherwise to 3'b000. The comparison uses pos_y before any update on the same edge.
- Illegal parameter sets (SPEED = 0, Y_MAX - Y_MIN < HEIGHT, START_POSY out of bounds) are stopped by an elaboration-time check.

## Timing

- rgb latency: 1 tick from row/col.
- pos_y, moving, step and hold change on the same edge as the move event.
- A pos_y change is visible in rgb for row/col presented on the cycle after that edge.
- With step_en held high, one move event occurs every SPEED ticks. The first event after reset comes on the SPEED-th step_en pulse.
- Control inputs are sampled only on move-event edges. Toggles between events are ignored.
- Reset asserted mid-motion clears everything immediately, without waiting for a tick. After reset deasserts, the timer restarts from 0.

## Test plan

Parameters for all scenarios: SPEED = 2, ACCEL_HOLD = 3, STEP_INIT = 1, STEP_MAX = 4, HEIGHT = 70, Y_MIN = 0, Y_MAX = 480, START_POSX = 100, START_POSY = 100. step_en is held at 1.

1. Pulse reset, then apply no controls for 10 ticks: pos_y = 100, rgb = 0, moving = 0 throughout.
2. Hold down for 14 ticks: pos_y after each event is 101, 102, 103, 105, 107, 109, 112, with moving = 1 on each event.
3. From a state with pos_y = 2 and step = 3, hold up: the next event gives pos_y = 0, the following event gives pos_y = 0 with moving = 0. From pos_y = 405 with down held: 410, then stays at 410.
4. After accelerating to step = 3, assert up and down together for one event: pos_y unchanged, moving = 0. Then press down only: the next move is +1.
5. With pos_y = 100, drive row/col = (100,100) → rgb = 111 one tick later.
   - (100,110) → 000.
   - (169,109) → 111.
   - (170,105) → 000.
6. Assert reset asynchronously between edges while moving down at step 2: pos_y = 100 and rgb = 0 immediately. The first move after release comes on the 2nd step_en pulse with step 1.
